range_parser: RTL and testbench

//   Byte-stream front end for the day-2 ID-range datapath. Parses ASCII "lo-hi" pairs

---
 rtl/range_parser_if.sv | 30 +++
 rtl/range_parser.sv | 142 ++++++++++++++
 tb/tb_range_parser.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/range_parser_if.sv
// rtl/range_parser_if.sv - byte-in / range-out handshake bundle for range_parser
interface range_parser_if #(
    parameter int DATA_WIDTH = 40
);
    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  in_last;
    logic                  in_ready;
    logic                  range_valid;
    logic [DATA_WIDTH-1:0] range_lo;
    logic [DATA_WIDTH-1:0] range_hi;
    logic [3:0]            lo_digs;
    logic [3:0]            hi_digs;
    logic                  range_ready;
    logic [15:0]           range_count;
    logic                  done;
    logic                  err;

    modport slave (
        input  in_valid, in_data, in_last, range_ready,
        output in_ready, range_valid, range_lo, range_hi, lo_digs, hi_digs,
               range_count, done, err
    );

    modport master (
        output in_valid, in_data, in_last, range_ready,
        input  in_ready, range_valid, range_lo, range_hi, lo_digs, hi_digs,
               range_count, done, err
    );
endinterface

// File: rtl/range_parser.sv
// rtl/range_parser.sv - parses ASCII "lo-hi" pairs into binary bounds with digit counts
module range_parser #(
    parameter int DATA_WIDTH = 40,
    parameter int MAX_DIGITS = 10
) (
    input  logic          clock,
    input  logic          reset_n,
    range_parser_if.slave bus
);
    localparam int AW = DATA_WIDTH + 4;

    typedef enum logic [2:0] {S_LO, S_HI, S_EMIT, S_DONE, S_ERR} state_t;

    state_t                state, state_n;
    logic [DATA_WIDTH-1:0] acc, acc_n;
    logic [3:0]            digs, digs_n;
    logic [DATA_WIDTH-1:0] lo_q, lo_n, hi_q, hi_n;
    logic [3:0]            lo_digs_q, lo_digs_n, hi_digs_q, hi_digs_n;
    logic [15:0]           count_q, count_n;
    logic                  pend_q, pend_n;
    logic                  end_range;

    logic          is_digit, is_dash, is_sep, is_ign, fire, ovf, in_ready_int;
    logic [3:0]    dval;
    logic [AW-1:0] acc_ext;

    assign is_digit = (bus.in_data >= 8'h30) && (bus.in_data <= 8'h39);
    assign is_dash  = (bus.in_data == 8'h2D);
    assign is_sep   = (bus.in_data == 8'h2C) || (bus.in_data == 8'h0A);
    assign is_ign   = (bus.in_data == 8'h20) || (bus.in_data == 8'h0D);
    // ASCII digits sit at 0x30-0x39, so the low nibble is the value
    assign dval     = bus.in_data[3:0];
    assign acc_ext  = {4'd0, acc} * AW'(10) + AW'(dval);
    assign ovf      = |acc_ext[AW-1:DATA_WIDTH];

    assign in_ready_int = (state == S_LO) || (state == S_HI) || (state == S_ERR);
    assign fire         = bus.in_valid && in_ready_int;

    always_comb begin
        state_n   = state;
        acc_n     = acc;
        digs_n    = digs;
        lo_n      = lo_q;
        hi_n      = hi_q;
        lo_digs_n = lo_digs_q;
        hi_digs_n = hi_digs_q;
        count_n   = count_q;
        pend_n    = pend_q;
        end_range = 1'b0;
        case (state)
            S_LO, S_HI: begin
                if (fire) begin
                    if (is_digit) begin
                        if (ovf || int'(digs) >= MAX_DIGITS) begin
                            state_n = S_ERR;
                        end else begin
                            acc_n  = acc_ext[DATA_WIDTH-1:0];
                            digs_n = digs + 4'd1;
                        end
                    end else if (state == S_LO) begin
                        if (is_dash && digs != 4'd0) begin
                            lo_n      = acc;
                            lo_digs_n = digs;
                            acc_n     = '0;
                            digs_n    = '0;
                            state_n   = S_HI;
                        end else if (!((is_sep || is_ign) && digs == 4'd0)) begin
                            state_n = S_ERR;
                        end
                    end else begin
                        if (is_sep && digs != 4'd0) end_range = 1'b1;
                        else if (!is_ign)           state_n = S_ERR;
                    end
                    // in_last is judged on the state left behind by this byte
                    if (bus.in_last && state_n != S_ERR) begin
                        if (state_n == S_LO && digs_n == 4'd0) begin
                            state_n = S_DONE;
                        end else if (state_n == S_HI && digs_n != 4'd0) begin
                            end_range = 1'b1;
                            pend_n    = 1'b1;
                        end else begin
                            state_n = S_ERR;
                        end
                    end
                    if (end_range && state_n != S_ERR) begin
                        if (lo_q > acc_n) begin
                            state_n = S_ERR;
                        end else begin
                            hi_n      = acc_n;
                            hi_digs_n = digs_n;
                            acc_n     = '0;
                            digs_n    = '0;
                            state_n   = S_EMIT;
                        end
                    end
                end
            end
            S_EMIT: begin
                if (bus.range_ready) begin
                    if (count_q != 16'hFFFF) count_n = count_q + 16'd1;
                    state_n = pend_q ? S_DONE : S_LO;
                    pend_n  = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_LO;
            acc       <= '0;
            digs      <= '0;
            lo_q      <= '0;
            hi_q      <= '0;
            lo_digs_q <= '0;
            hi_digs_q <= '0;
            count_q   <= '0;
            pend_q    <= 1'b0;
        end else begin
            state     <= state_n;
            acc       <= acc_n;
            digs      <= digs_n;
            lo_q      <= lo_n;
            hi_q      <= hi_n;
            lo_digs_q <= lo_digs_n;
            hi_digs_q <= hi_digs_n;
            count_q   <= count_n;
            pend_q    <= pend_n;
        end
    end

    assign bus.in_ready    = in_ready_int;
    assign bus.range_valid = (state == S_EMIT);
    assign bus.range_lo    = lo_q;
    assign bus.range_hi    = hi_q;
    assign bus.lo_digs     = lo_digs_q;
    assign bus.hi_digs     = hi_digs_q;
    assign bus.range_count = count_q;
    assign bus.done        = (state == S_DONE);
    assign bus.err         = (state == S_ERR);
endmodule

// File: tb/tb_range_parser.sv
// tb/tb_range_parser.sv - directed-vector bench for range_parser with field-level reference model
module tb_range_parser;
    localparam int DW   = 40;
    localparam int MAXD = 10;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    range_parser_if #(.DATA_WIDTH(DW)) bus();
    range_parser #(.DATA_WIDTH(DW), .MAX_DIGITS(MAXD)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    typedef struct {longint lo; longint hi; int ld; int hd;} rng_t;
    rng_t exp_q[$];
    rng_t got_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic bit is_dig(input byte c);
        return c >= "0" && c <= "9";
    endfunction

    function automatic bit is_ig(input byte c);
        return c == 8'h20 || c == 8'h0d;
    endfunction

    // Classifies one separator-delimited field: 0 blank, 1 range, 2 malformed, 3 valid prefix
    function automatic int field(input string f, input bit complete, output rng_t r);
        int dash = -1, nd = 0, stop, j, lc = 0, hc = 0;
        longint lv = 0, hv = 0;
        r = '{0, 0, 0, 0};
        for (int i = 0; i < f.len(); i++) begin
            if (!(is_dig(f[i]) || is_ig(f[i]) || f[i] == "-")) return 2;
            if (f[i] == "-") begin nd++; dash = i; end
        end
        if (nd > 1) return 2;
        stop = (dash < 0) ? f.len() : dash;
        j = 0;
        while (j < stop && is_ig(f[j])) j++;
        for (int k = j; k < stop; k++) begin
            if (!is_dig(f[k])) return 2;
            lc++;
            lv = lv * 10 + longint'(f[k] - "0");
        end
        if (lc > MAXD) return 2;
        if (dash < 0) return (lc == 0) ? (complete ? 0 : 3) : (complete ? 2 : 3);
        if (lc == 0) return 2;
        for (int k = dash + 1; k < f.len(); k++) begin
            if (!is_ig(f[k])) begin
                hc++;
                hv = hv * 10 + longint'(f[k] - "0");
            end
        end
        if (hc > MAXD) return 2;
        if (!complete) return 3;
        if (hc == 0) return 2;
        if (lv >= (longint'(1) << DW) || hv >= (longint'(1) << DW)) return 2;
        if (lv > hv) return 2;
        r = '{lv, hv, lc, hc};
        return 1;
    endfunction

    function automatic void model(input string s, input bit last, output bit e, output bit d);
        string cur = "";
        rng_t  r;
        int    st;
        e = 1'b0;
        d = 1'b0;
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] == "," || s[i] == 8'h0a) begin
                st = field(cur, 1'b1, r);
                if (st == 2) begin e = 1'b1; return; end
                if (st == 1) exp_q.push_back(r);
                cur = "";
            end else begin
                cur = {cur, s.substr(i, i)};
            end
        end
        st = field(cur, last, r);
        if (st == 2) e = 1'b1;
        else if (last) begin
            if (st == 1) exp_q.push_back(r);
            d = 1'b1;
        end
    endfunction

    always @(negedge clock) begin
        if (reset_n) begin
            if (bus.range_valid) begin
                check("in_ready_in_emit", bus.in_ready, 0);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_range: got lo=%0d hi=%0d expected none",
                             bus.range_lo, bus.range_hi);
                end else begin
                    check("range_lo", bus.range_lo, exp_q[0].lo);
                    check("range_hi", bus.range_hi, exp_q[0].hi);
                    check("lo_digs", bus.lo_digs, exp_q[0].ld);
                    check("hi_digs", bus.hi_digs, exp_q[0].hd);
                    if (bus.range_ready) begin
                        got_q.push_back('{longint'(bus.range_lo), longint'(bus.range_hi),
                                          int'(bus.lo_digs), int'(bus.hi_digs)});
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (bus.err) begin
                check("err_in_ready", bus.in_ready, 1);
                check("err_no_valid", bus.range_valid, 0);
            end
            if (bus.done) check("done_in_ready", bus.in_ready, 0);
        end
    end

    task automatic check_reset_state();
        check("rst_valid", bus.range_valid, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_count", bus.range_count, 0);
        check("rst_done", bus.done, 0);
        check("rst_err", bus.err, 0);
        check("rst_lo", bus.range_lo, 0);
        check("rst_hi", bus.range_hi, 0);
    endtask

    task automatic do_reset();
        reset_n         = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_data     = 8'h00;
        bus.in_last     = 1'b0;
        bus.range_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        exp_q.delete();
        got_q.delete();
        reset_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input byte b, input bit l);
        int t   = 0;
        bit acc = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        bus.in_last  = l;
        while (!acc && t < 200) begin
            @(negedge clock);
            acc = bus.in_ready;
            @(posedge clock);
            #1;
            t++;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL byte_accept_timeout: got no in_ready expected acceptance of 0x%02h", b);
        end
    endtask

    task automatic send_str(input string s, input bit last);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], last && (i == s.len() - 1));
    endtask

    task automatic wait_valid(input string name);
        int t = 0;
        while (!bus.range_valid && t < 50) begin @(posedge clock); #1; t++; end
        check(name, bus.range_valid, 1);
    endtask

    task automatic finish_check(input string name, input int n, input bit e, input bit d);
        int t = 0;
        while ((exp_q.size() != 0 || bus.range_valid) && t < 100) begin
            @(posedge clock);
            #1;
            t++;
        end
        repeat (2) @(posedge clock);
        #1;
        check({name, "_pending"}, exp_q.size(), 0);
        check({name, "_count"}, bus.range_count, n);
        check({name, "_done"}, bus.done, d);
        check({name, "_err"}, bus.err, e);
    endtask

    task automatic run(input string name, input string s, input bit last);
        bit e, d;
        int n;
        do_reset();
        model(s, last, e, d);
        n = exp_q.size();
        send_str(s, last);
        finish_check(name, n, e, d);
    endtask

    initial begin
        bit e, d;
        int n;

        reset_n         = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_data     = 8'h00;
        bus.in_last     = 1'b0;
        bus.range_ready = 1'b1;
        @(posedge clock);
        #1;
        check_reset_state();

        run("two_ranges", "11-22,95-115\n", 1'b1);
        check("t1_n", got_q.size(), 2);
        if (got_q.size() >= 2) begin
            check("t1_lo0", got_q[0].lo, 11);
            check("t1_hi0", got_q[0].hi, 22);
            check("t1_hd1", got_q[1].hd, 3);
            check("t1_hi1", got_q[1].hi, 115);
        end
        check("t1_done", bus.done, 1);

        do_reset();
        bus.range_ready = 1'b0;
        model("1-9,", 1'b0, e, d);
        n = exp_q.size();
        send_str("1-9,", 1'b0);
        wait_valid("stall_valid");
        repeat (5) begin
            @(negedge clock);
            check("stall_hold_valid", bus.range_valid, 1);
            check("stall_hold_in_ready", bus.in_ready, 0);
            check("stall_hold_lo", bus.range_lo, 1);
            check("stall_hold_hi", bus.range_hi, 9);
        end
        @(posedge clock);
        #1;
        bus.range_ready = 1'b1;
        finish_check("stall", n, e, d);
        check("stall_transfers", got_q.size(), 1);

        run("last_on_digit", "998-1012", 1'b1);
        check("t3_n", got_q.size(), 1);
        if (got_q.size() >= 1) begin
            check("t3_lo", got_q[0].lo, 998);
            check("t3_hd", got_q[0].hd, 4);
        end
        check("t3_done", bus.done, 1);

        run("too_many_digits", "12345678901-2,3-4,", 1'b0);
        check("t4_err", bus.err, 1);
        check("t4_none", got_q.size(), 0);

        run("lo_gt_hi", "5-3,", 1'b0);
        check("t5a_err", bus.err, 1);
        run("leading_dash", "-4,", 1'b0);
        check("t5b_err", bus.err, 1);
        run("bad_char", "1-2x", 1'b0);
        check("t5c_err", bus.err, 1);

        run("leading_zeros", "007-010,\n", 1'b1);
        if (got_q.size() >= 1) begin
            check("t7_ld", got_q[0].ld, 3);
            check("t7_lo", got_q[0].lo, 7);
        end

        do_reset();
        bus.range_ready = 1'b0;
        model(",,\n 7-7,", 1'b0, e, d);
        send_str(",,\n 7-7,", 1'b0);
        wait_valid("rst_emit_valid");
        check("rst_emit_lo", bus.range_lo, 7);
        check("rst_emit_ld", bus.lo_digs, 1);
        reset_n = 1'b0;
        #1;
        check("rst_emit_drop", bus.range_valid, 0);
        check_reset_state();
        do_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
